// File: rtl/pixel_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_writer_pkg
// Purpose  : Shared types and constants for the rasteriser pixel writer.
// Revision : 1.0  initial release
// ============================================================================
package pixel_writer_pkg;

    // Default screen geometry and datapath widths
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int ADDR_W_DEF   = 19;
    localparam int COLOR_W_DEF  = 8;

    // Point as produced by the line drawer: x in the upper half, y in the lower
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
    } point2d_t;

    // One framebuffer write at the default widths
    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  addr;
        logic [COLOR_W_DEF-1:0] color;
    } pixel_write_t;

    // Write FSM state encoding
    typedef logic [1:0] wr_state_t;
    localparam wr_state_t ST_IDLE  = 2'd0;
    localparam wr_state_t ST_WRITE = 2'd1;
    localparam wr_state_t ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pixel_writer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo
// Purpose  : Synchronous FIFO with a type parameter for the payload.
//            A push while full is accepted when a pop happens in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module pixel_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Extra pointer bit distinguishes full from empty when indices match
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= din;
        end
    end

    // Read and write pointers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_writer
// Purpose  : Clips line-drawer pixels to the screen, converts them to linear
//            framebuffer addresses, queues them and writes them over a
//            req/ack port. Pulses flush_done when a finished line is committed.
// Revision : 1.0  initial release
// ============================================================================
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int SCREEN_W   = SCREEN_W_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int COLOR_W    = COLOR_W_DEF
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               plot,
    input  logic [31:0]        point,
    input  logic [COLOR_W-1:0] color,
    input  logic               line_done,
    input  logic               clear_status,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic               busy,
    output logic               flush_done,
    output logic               overflow,
    output logic [15:0]        clip_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pix_entry_t;

    point2d_t            s1_point;
    logic [COLOR_W-1:0]  s1_color;
    logic                s1_valid;
    logic                clipped;
    logic                pix_ok;
    logic [ADDR_W-1:0]   pix_addr;
    pix_entry_t          push_entry;
    pix_entry_t          fifo_head;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    wr_state_t           state;
    wr_state_t           state_nx;
    logic                flush_pending;

    // Input stage: capture the pixel on a plot strobe
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid <= 1'b0;
            s1_point <= '0;
            s1_color <= '0;
        end else begin
            s1_valid <= plot;
            if (plot) begin
                s1_point <= point;
                s1_color <= color;
            end
        end
    end

    // Off-screen test; sign bits catch the negative coordinates
    assign clipped = s1_point.x[15] | s1_point.y[15]
                   | (int'(s1_point.x) >= SCREEN_W)
                   | (int'(s1_point.y) >= SCREEN_H);
    assign pix_ok  = s1_valid & ~clipped;

    // Only meaningful for on-screen pixels, so unsigned operands are safe
    assign pix_addr = ADDR_W'($unsigned(s1_point.y)) * ADDR_W'(SCREEN_W)
                    + ADDR_W'($unsigned(s1_point.x));

    assign push_entry.addr  = pix_addr;
    assign push_entry.color = s1_color;
    assign fifo_push        = pix_ok & (~fifo_full | fifo_pop);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (pix_entry_t)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_entry),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Write FSM next state and pop decision; queued pixels win over DONE
    always_comb begin
        state_nx = state;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nx = ST_WRITE;
                    fifo_pop = 1'b1;
                end else if (flush_pending && !s1_valid) begin
                    state_nx = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // State and write-port registers; address/data only change on a pop
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nx;
            if (fifo_pop) begin
                mem_addr  <= fifo_head.addr;
                mem_wdata <= fifo_head.color;
            end
        end
    end

    // Line-complete request; a new line_done beats the clear on DONE entry
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            flush_pending <= 1'b0;
        end else if (line_done) begin
            flush_pending <= 1'b1;
        end else if ((state == ST_IDLE) && (state_nx == ST_DONE)) begin
            flush_pending <= 1'b0;
        end
    end

    // Sticky overflow and saturating clip counter; clear has priority
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow   <= 1'b0;
            clip_count <= '0;
        end else if (clear_status) begin
            overflow   <= 1'b0;
            clip_count <= '0;
        end else begin
            if (pix_ok && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            if (s1_valid && clipped && (clip_count != 16'hFFFF)) begin
                clip_count <= clip_count + 16'd1;
            end
        end
    end

    assign mem_we     = (state == ST_WRITE);
    assign flush_done = (state == ST_DONE);
    assign busy       = s1_valid | (fifo_count != '0) | (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_writer
// Purpose  : Directed self-checking bench for pixel_writer.
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_writer;

    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 8;

    logic               clk          = 1'b0;
    logic               n_rst        = 1'b0;
    logic               plot         = 1'b0;
    logic [31:0]        point        = '0;
    logic [COLOR_W-1:0] color        = '0;
    logic               line_done    = 1'b0;
    logic               clear_status = 1'b0;
    logic               mem_ack      = 1'b0;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_wdata;
    logic               mem_we;
    logic               busy;
    logic               flush_done;
    logic               overflow;
    logic [15:0]        clip_count;

    int n_vec = 0;
    int n_err = 0;

    // Accepted writes as {addr, data}
    logic [ADDR_W+COLOR_W-1:0] wr_q[$];

    always #5 clk = ~clk;

    pixel_writer #(
        .SCREEN_W   (640),
        .SCREEN_H   (480),
        .FIFO_DEPTH (8),
        .ADDR_W     (ADDR_W),
        .COLOR_W    (COLOR_W)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .plot         (plot),
        .point        (point),
        .color        (color),
        .line_done    (line_done),
        .clear_status (clear_status),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .busy         (busy),
        .flush_done   (flush_done),
        .overflow     (overflow),
        .clip_count   (clip_count)
    );

    // Record each handshake that the coming rising edge will complete
    always @(negedge clk) begin
        if (n_rst && mem_we && mem_ack) begin
            wr_q.push_back({mem_addr, mem_wdata});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pixel at the line-drawer rate of one per three cycles
    task automatic plot_px(input logic signed [15:0] x, input logic signed [15:0] y,
                           input logic [7:0] c);
        tick();
        plot  = 1'b1;
        point = {x, y};
        color = c;
        tick();
        plot  = 1'b0;
        tick();
    endtask

    initial begin
        logic [ADDR_W+COLOR_W-1:0] exp_wr;
        int acks;
        int pulses;
        int ack3_cyc;
        int fd_seen;

        // Reset values
        @(negedge clk);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_wdata",  32'(mem_wdata),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        check("rst_clip_count", 32'(clip_count), 32'd0);
        @(posedge clk);
        #1 n_rst = 1'b1;

        // Single pixel (10,2): write in N+3, flush_done two cycles after the ack
        mem_ack = 1'b1;
        wr_q.delete();
        tick();                                    // cycle N
        plot = 1'b1; point = {16'sd10, 16'sd2}; color = 8'h5A;
        @(negedge clk);
        check("t1_we_N", 32'(mem_we), 32'd0);
        tick();                                    // N+1
        plot = 1'b0; line_done = 1'b1;
        @(negedge clk);
        check("t1_busy_N1", 32'(busy), 32'd1);
        tick();                                    // N+2
        line_done = 1'b0;
        @(negedge clk);
        check("t1_we_N2", 32'(mem_we), 32'd0);
        tick();                                    // N+3
        @(negedge clk);
        check("t1_we_N3",    32'(mem_we),    32'd1);
        check("t1_addr_N3",  32'(mem_addr),  32'd1290);
        check("t1_wdata_N3", 32'(mem_wdata), 32'h5A);
        tick();                                    // N+4
        @(negedge clk);
        check("t1_fd_N4", 32'(flush_done), 32'd0);
        tick();                                    // N+5
        @(negedge clk);
        check("t1_fd_N5", 32'(flush_done), 32'd1);
        tick();                                    // N+6
        @(negedge clk);
        check("t1_fd_N6",   32'(flush_done), 32'd0);
        check("t1_busy_N6", 32'(busy),       32'd0);
        check("t1_nwr",     32'(wr_q.size()), 32'd1);

        // Clipped pixels: no writes, counter counts, line_done still flushes
        wr_q.delete();
        plot_px(-16'sd1, 16'sd0,   8'h01);
        plot_px(16'sd640, 16'sd5,  8'h02);
        plot_px(16'sd0,  16'sd480, 8'h03);
        plot_px(16'sd3,  -16'sd7,  8'h04);
        tick();
        tick();
        @(negedge clk);
        check("t2_clip_count", 32'(clip_count), 32'd4);
        check("t2_nwr",        32'(wr_q.size()), 32'd0);
        tick();                                    // L
        line_done = 1'b1;
        tick();                                    // L+1
        line_done = 1'b0;
        @(negedge clk);
        check("t2_fd_L1", 32'(flush_done), 32'd0);
        tick();                                    // L+2
        @(negedge clk);
        check("t2_fd_L2", 32'(flush_done), 32'd1);
        tick();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        @(negedge clk);
        check("t2_clip_clear", 32'(clip_count), 32'd0);

        // Screen corners
        wr_q.delete();
        plot_px(16'sd639, 16'sd479, 8'hA1);
        plot_px(16'sd0,   16'sd0,   8'hB2);
        repeat (4) tick();
        @(negedge clk);
        check("t3_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("t3_corner_max", 32'(wr_q[0]), 32'({19'd307199, 8'hA1}));
            check("t3_corner_min", 32'(wr_q[1]), 32'({19'd0, 8'hB2}));
        end
        check("t3_clip_none", 32'(clip_count), 32'd0);

        // Overflow: ack held low, ten pixels, the tenth is dropped
        mem_ack = 1'b0;
        wr_q.delete();
        for (int i = 0; i < 9; i++) begin
            plot_px(16'(i), 16'sd1, 8'(8'h10 + i));
        end
        @(negedge clk);
        check("t4_ovf_before", 32'(overflow), 32'd0);
        plot_px(16'sd9, 16'sd1, 8'h19);
        @(negedge clk);
        check("t4_ovf_after", 32'(overflow), 32'd1);
        check("t4_nwr_held",  32'(wr_q.size()), 32'd0);
        tick();
        mem_ack = 1'b1;
        repeat (14) tick();
        @(negedge clk);
        check("t4_nwr", 32'(wr_q.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            exp_wr = {19'(640 + i), 8'(8'h10 + i)};
            if (i < wr_q.size()) begin
                check($sformatf("t4_wr%0d", i), 32'(wr_q[i]), 32'(exp_wr));
            end
        end
        tick();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        @(negedge clk);
        check("t4_ovf_clear", 32'(overflow), 32'd0);

        // line_done with three pixels queued, ack every second cycle
        mem_ack = 1'b0;
        wr_q.delete();
        plot_px(16'sd0, 16'sd3, 8'hC0);
        plot_px(16'sd1, 16'sd3, 8'hC1);
        plot_px(16'sd2, 16'sd3, 8'hC2);
        tick();
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
        acks     = 0;
        pulses   = 0;
        ack3_cyc = -100;
        for (int c = 0; c < 20; c++) begin
            mem_ack = ((c % 2) == 1);
            @(negedge clk);
            if (mem_we && mem_ack) begin
                acks++;
                if (acks == 3) ack3_cyc = c;
            end
            if (flush_done) begin
                pulses++;
                check("t5_fd_acks",  32'(acks),         32'd3);
                check("t5_fd_delay", 32'(c - ack3_cyc), 32'd2);
            end
            tick();
        end
        mem_ack = 1'b0;
        check("t5_fd_pulses", 32'(pulses),      32'd1);
        check("t5_nwr",       32'(wr_q.size()), 32'd3);

        // Asynchronous reset during a write with four pixels queued
        wr_q.delete();
        for (int i = 0; i < 5; i++) begin
            plot_px(16'(i), 16'sd4, 8'(8'hD0 + i));
        end
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
        @(negedge clk);
        check("t6_we_before", 32'(mem_we), 32'd1);
        tick();
        #2 n_rst = 1'b0;
        #1;
        check("t6_we_async",   32'(mem_we),     32'd0);
        check("t6_busy_async", 32'(busy),       32'd0);
        check("t6_addr_async", 32'(mem_addr),   32'd0);
        check("t6_data_async", 32'(mem_wdata),  32'd0);
        check("t6_fd_async",   32'(flush_done), 32'd0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        mem_ack = 1'b1;
        fd_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (flush_done) fd_seen++;
            tick();
        end
        check("t6_nwr_after", 32'(wr_q.size()), 32'd0);
        check("t6_fd_after",  32'(fd_seen),     32'd0);
        check("t6_busy_after", 32'(busy),       32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
